// File: rtl/grn_attractor_ctrl_if.sv
// Host and node-array signal bundle for the GRN attractor controller.
// The slave side is the controller; the master side drives start/config and the node outputs.
interface grn_attractor_ctrl_if #(
   parameter int unsigned N_NODES = 8,
   parameter int unsigned CNT_W   = 16
);
   logic               start;
   logic [N_NODES-1:0] init_in;
   logic [CNT_W-1:0]   max_steps;
   logic [N_NODES-1:0] s0_vec;
   logic [N_NODES-1:0] s1_vec;
   logic               reset_nos;
   logic               start_s0;
   logic               start_s1;
   logic [N_NODES-1:0] init_state;
   logic               busy;
   logic               done;
   logic               timeout;
   logic [CNT_W-1:0]   transient;
   logic [CNT_W-1:0]   period;
   logic [N_NODES-1:0] attractor;

   modport master (
      output start, init_in, max_steps, s0_vec, s1_vec,
      input  reset_nos, start_s0, start_s1, init_state,
      input  busy, done, timeout, transient, period, attractor
   );

   modport slave (
      input  start, init_in, max_steps, s0_vec, s1_vec,
      output reset_nos, start_s0, start_s1, init_state,
      output busy, done, timeout, transient, period, attractor
   );
endinterface

// File: rtl/grn_attractor_ctrl.sv
// Brent/Floyd-style cycle finder over an array of node cells: finds the meet point,
// the attractor period and the transient length, bounded by max_steps.
module grn_attractor_ctrl #(
   parameter int unsigned N_NODES = 8,
   parameter int unsigned CNT_W   = 16
) (
   input logic                clk,
   input logic                rst,
   grn_attractor_ctrl_if.slave bus
);
   typedef enum logic [3:0] {
      IDLE, LOAD, MEET_A, MEET_B, MEET_CHK, PER_STEP, PER_CHK,
      MU_LOAD, MU_RUN, MU_A, MU_B, MU_CHK, FINISH
   } state_t;

   state_t             state, nxt;
   logic [CNT_W-1:0]   t_q, t_d;
   logic [CNT_W-1:0]   max_q, max_d;
   logic [CNT_W-1:0]   period_q, period_d;
   logic [CNT_W-1:0]   transient_q, transient_d;
   logic [N_NODES-1:0] init_q, init_d;
   logic [N_NODES-1:0] attractor_q, attractor_d;
   logic               timeout_q, timeout_d;
   logic               busy_q, busy_d;
   logic               done_q;
   logic               reset_nos_q, start_s0_q, start_s1_q;
   logic [CNT_W-1:0]   t_inc;

   // Saturating increment so no counter can ever wrap.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction

   assign t_inc = sat_inc(t_q);

   // Next-state and datapath update.
   always_comb begin
      nxt         = state;
      t_d         = t_q;
      max_d       = max_q;
      init_d      = init_q;
      period_d    = period_q;
      transient_d = transient_q;
      attractor_d = attractor_q;
      timeout_d   = timeout_q;
      busy_d      = busy_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               init_d      = bus.init_in;
               max_d       = bus.max_steps;
               period_d    = '0;
               transient_d = '0;
               attractor_d = '0;
               timeout_d   = 1'b0;
               busy_d      = 1'b1;
               nxt         = LOAD;
            end
         end
         LOAD: begin
            t_d = '0;
            nxt = MEET_A;
         end
         MEET_A: nxt = MEET_B;
         MEET_B: begin
            t_d = t_inc;
            nxt = MEET_CHK;
         end
         MEET_CHK: begin
            if (bus.s0_vec == bus.s1_vec) begin
               attractor_d = bus.s0_vec;
               t_d         = '0;
               nxt         = PER_STEP;
            end else if (t_q >= max_q) begin
               timeout_d = 1'b1;
               nxt       = FINISH;
            end else begin
               nxt = MEET_A;
            end
         end
         PER_STEP: begin
            period_d = sat_inc(period_q);
            nxt      = PER_CHK;
         end
         PER_CHK: begin
            if (bus.s1_vec == attractor_q) begin
               nxt = MU_LOAD;
            end else if (period_q >= max_q) begin
               timeout_d = 1'b1;
               period_d  = '0;
               nxt       = FINISH;
            end else begin
               nxt = PER_STEP;
            end
         end
         MU_LOAD: begin
            t_d = '0;
            nxt = MU_RUN;
         end
         // Hare gets a head start of exactly one period.
         MU_RUN: begin
            t_d = t_inc;
            if (t_inc >= period_q) nxt = MU_CHK;
         end
         MU_CHK: begin
            if (bus.s0_vec == bus.s1_vec) begin
               nxt = FINISH;
            end else if (transient_q >= max_q) begin
               timeout_d   = 1'b1;
               period_d    = '0;
               transient_d = '0;
               nxt         = FINISH;
            end else begin
               nxt = MU_A;
            end
         end
         MU_A: nxt = MU_B;
         MU_B: begin
            transient_d = sat_inc(transient_q);
            nxt         = MU_CHK;
         end
         FINISH: begin
            busy_d = 1'b0;
            nxt    = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // State, datapath and strobes registered from the upcoming state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         t_q         <= '0;
         max_q       <= '0;
         init_q      <= '0;
         period_q    <= '0;
         transient_q <= '0;
         attractor_q <= '0;
         timeout_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         reset_nos_q <= 1'b0;
         start_s0_q  <= 1'b0;
         start_s1_q  <= 1'b0;
      end else begin
         state       <= nxt;
         t_q         <= t_d;
         max_q       <= max_d;
         init_q      <= init_d;
         period_q    <= period_d;
         transient_q <= transient_d;
         attractor_q <= attractor_d;
         timeout_q   <= timeout_d;
         busy_q      <= busy_d;
         done_q      <= (nxt == FINISH);
         reset_nos_q <= (nxt == LOAD) || (nxt == MU_LOAD);
         start_s0_q  <= (nxt == MEET_A) || (nxt == MEET_B) || (nxt == MU_A) || (nxt == MU_B);
         start_s1_q  <= (nxt == MEET_A) || (nxt == MEET_B) || (nxt == PER_STEP) ||
                        (nxt == MU_RUN) || (nxt == MU_A);
      end
   end

   assign bus.reset_nos  = reset_nos_q;
   assign bus.start_s0   = start_s0_q;
   assign bus.start_s1   = start_s1_q;
   assign bus.init_state = init_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.timeout    = timeout_q;
   assign bus.period     = period_q;
   assign bus.transient  = transient_q;
   assign bus.attractor  = attractor_q;
endmodule

// File: doc/grn_attractor_ctrl.md
GRN_ATTRACTOR_CTRL -- requirements
Module: grn_attractor_ctrl

Interface
REQ-001 SHALL have parameter N_NODES, default 8, giving the number of node cells driven (state vector width).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of all step counters and result fields.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1; a one-cycle pulse launches a run; ignored while busy=1.
REQ-006 SHALL have port init_in, input, N_NODES; the initial state, captured on an accepted start.
REQ-007 SHALL have port max_steps, input, CNT_W; the iteration limit, captured on an accepted start.
REQ-008 SHALL have ports s0_vec and s1_vec, input, N_NODES each; the concatenated node s0/s1 outputs (bit i = node i).
REQ-009 SHALL have ports reset_nos, start_s0 and start_s1, output, 1 each; broadcast to all node cells.
REQ-010 SHALL have port init_state, output, N_NODES; bit i drives node i init_state and holds the captured init_in.
REQ-011 SHALL have ports busy, done and timeout, output, 1 each; done is a one-cycle pulse, and timeout is valid with done.
REQ-012 SHALL have ports transient and period, output, CNT_W each, plus attractor, output, N_NODES; all hold until the next accepted start.

Function (node contract: reset_nos loads s0=s1=init and arms s0; each start_s1 advances s1 one step; start_s0 advances s0 on alternate strobes, first strobe after reset_nos advances)
REQ-013 SHALL implement FSM states IDLE, LOAD, MEET_A, MEET_B, MEET_CHK, PER_STEP, PER_CHK, MU_LOAD, MU_RUN, MU_A, MU_B, MU_CHK, FINISH.
REQ-014 IDLE: on start, SHALL capture init_in and max_steps, clear results, clear timeout, set busy=1, and go to LOAD.
REQ-015 LOAD: SHALL assert reset_nos for exactly 1 cycle, clear iteration counter t, and go to MEET_A.
REQ-016 MEET_A: SHALL assert start_s0 and start_s1. MEET_B: SHALL assert start_s0 and start_s1. Net effect: s1 advances 2 steps and s0 advances 1 step; t increments.
REQ-017 MEET_CHK (no strobes): if s0_vec==s1_vec, SHALL latch attractor=s0_vec, clear the counter, and go to PER_STEP; else if t>=max_steps, SHALL go to FINISH with timeout=1; else SHALL go to MEET_A.
REQ-018 PER_STEP: SHALL assert start_s1 only; period increments. PER_CHK: if s1_vec==attractor, SHALL go to MU_LOAD; else if period>=max_steps, SHALL set timeout; else SHALL go to PER_STEP.
REQ-019 MU_LOAD: SHALL assert reset_nos for 1 cycle. MU_RUN: SHALL assert start_s1 only, for exactly period cycles, then go to MU_CHK.
REQ-020 MU_CHK: if s0_vec==s1_vec, SHALL go to FINISH with transient final; else if transient>=max_steps, SHALL set timeout; else SHALL go to MU_A.
REQ-021 MU_A SHALL assert start_s0 and start_s1; MU_B SHALL assert start_s0 only; transient increments; then MU_CHK.
REQ-022 FINISH: SHALL pulse done for 1 cycle, clear busy, and return to IDLE.
REQ-023 On timeout, period and transient SHALL read 0 and attractor SHALL hold its last latched value (0 if none was latched).
REQ-024 Outside the states that assert them, strobe outputs SHALL be 0; reset_nos SHALL never be asserted together with start_s0 or start_s1.
REQ-025 Comparisons SHALL use only the registered node outputs sampled in the CHK states; there SHALL be no combinational path from s0_vec/s1_vec to any strobe.
REQ-026 Counters SHALL be CNT_W bits and never wrap; the max_steps checks guarantee termination, and max_steps=0 SHALL yield timeout after the first MEET iteration unless a meet occurs.

Reset
REQ-027 While rst=0, SHALL force state IDLE, all outputs and counters to 0, and the captured init/max_steps to 0, asynchronously.
REQ-028 rst asserted mid-run SHALL abort the run without a done pulse; the first start after rst release SHALL run normally.

Verification (bench node model: N_NODES=3, s0/s1 replaced by next-state function f per scenario)
REQ-029 f(x)=x, init=3'd5, max_steps=10 -> done after 1 MEET iteration; period=1, transient=0, attractor=5, timeout=0.
REQ-030 f(x)=x+1 mod 8, init=0, max_steps=20 -> period=8, transient=0, timeout=0.
REQ-031 f(x)=min(x+1,5), init=0, max_steps=20 -> period=1, transient=5, attractor=5.
REQ-032 f(x)=x+1 mod 8, init=0, max_steps=2 -> done with timeout=1, period=0, transient=0.
REQ-033 start pulsed again while busy -> ignored, results unchanged; rst low during MU_RUN -> all outputs 0 immediately, no done.
REQ-034 In every run: reset_nos is high exactly 2 cycles per successful run, never overlaps a strobe, and busy falls the cycle after done.
